adc_frame_packer: RTL

//  Captures a block of ADC samples after an arm request and a trigger, then streams them as a framed

---
 rtl/scope_pkg.sv | 28 ++
 rtl/adc_frame_packer_if.sv | 11 +
 rtl/sample_buffer.sv | 24 ++
 rtl/adc_frame_packer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared constants, packer state type and sample slicing for the scope capture path.
// FRAME_CHECKSUM_EN adds the trailing checksum state to the packer state type.
package scope_pkg;

  localparam logic [7:0] FRAME_SYNC0 = 8'hA5;
  localparam logic [7:0] FRAME_SYNC1 = 8'h5A;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ARMED   = 4'd1,
    ST_CAPTURE = 4'd2,
    ST_HDR0    = 4'd3,
    ST_HDR1    = 4'd4,
    ST_LEN_HI  = 4'd5,
    ST_LEN_LO  = 4'd6,
    ST_DATA    = 4'd7
`ifdef FRAME_CHECKSUM_EN
    ,
    ST_CSUM    = 4'd8
`endif
  } packer_state_e;

  // Top byte of an ADC word of the given width (width >= 8).
  function automatic logic [7:0] sample_byte(input logic [31:0] raw, input int width);
    return 8'(raw >> (width - 32'sd8));
  endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// Valid/ready byte stream from the frame packer to the UART transmitter.
interface adc_frame_packer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sample_buffer.sv
// DEPTH x 8 simple dual-port sample store: one write port, registered read with 1-cycle latency.
module sample_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Write port and registered read port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Arms, triggers and captures DEPTH ADC sample bytes, then streams them as a framed byte sequence.
// Define FRAME_CHECKSUM_EN to append an XOR checksum byte after the samples.
module adc_frame_packer #(
  parameter int ADC_WIDTH  = 8,
  parameter int DEPTH      = 256,
  parameter int TRIG_LEVEL = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    trig_force,
  input  logic [ADC_WIDTH-1:0]    adc_data,
  input  logic                    adc_valid,
  adc_frame_packer_if.master      tx_if,
  output logic                    busy,
  output logic                    frame_done
);

  import scope_pkg::*;

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [15:0] DEPTH_W   = 16'(DEPTH);
  localparam logic [7:0]  TRIG_BYTE = 8'(TRIG_LEVEL);

  packer_state_e state_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          busy_q;
  logic          frame_done_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [7:0]    prev_sample_q;
  logic          prev_seen_q;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]    csum_q;
`endif

  logic [7:0]    samp_d;
  logic [7:0]    rd_data_d;
  logic          xfer_d;
  logic          trig_hit_d;
  logic          we_d;
  logic          rd_adv_d;
  logic [AW-1:0] rd_addr_d;

  assign samp_d = sample_byte(32'(adc_data), ADC_WIDTH);
  assign xfer_d = tx_valid_q && tx_if.tx_ready;

  // Trigger decision; a level crossing needs a previous sample taken in this arm cycle.
  always_comb begin
    trig_hit_d = 1'b0;
    if (trig_force) begin
      trig_hit_d = 1'b1;
    end else if (prev_seen_q && (prev_sample_q < TRIG_BYTE) && (samp_d >= TRIG_BYTE)) begin
      trig_hit_d = 1'b1;
    end else begin
      trig_hit_d = 1'b0;
    end
  end

  // Buffer write enable and read address; the read address runs one sample ahead of tx_data.
  always_comb begin
    we_d      = adc_valid && (((state_q == ST_ARMED) && trig_hit_d) || (state_q == ST_CAPTURE));
    rd_adv_d  = xfer_d && ((state_q == ST_LEN_LO) ||
                           ((state_q == ST_DATA) && (rd_ptr_q != {AW{1'b0}})));
    if (rd_adv_d) begin
      rd_addr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_addr_d = rd_ptr_q;
    end
  end

  sample_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .we_i    (we_d),
    .waddr_i (wr_ptr_q),
    .wdata_i (samp_d),
    .raddr_i (rd_addr_d),
    .rdata_o (rd_data_d)
  );

  // Packer FSM with registered stream outputs, pointers and trigger history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      prev_sample_q <= 8'h00;
      prev_seen_q   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum_q        <= 8'h00;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if (rd_adv_d) begin
        rd_ptr_q <= rd_addr_d;
      end
`ifdef FRAME_CHECKSUM_EN
      if (xfer_d) begin
        csum_q <= csum_q ^ tx_data_q;
      end
`endif
      case (state_q)
        ST_IDLE: begin
          // An arm coinciding with the end-of-frame pulse is dropped.
          if (arm && !frame_done_q) begin
            state_q     <= ST_ARMED;
            busy_q      <= 1'b1;
            prev_seen_q <= 1'b0;
            wr_ptr_q    <= {AW{1'b0}};
          end
        end
        ST_ARMED: begin
          if (adc_valid) begin
            prev_sample_q <= samp_d;
            prev_seen_q   <= 1'b1;
            if (trig_hit_d) begin
              state_q  <= ST_CAPTURE;
              wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
          end
        end
        ST_CAPTURE: begin
          if (adc_valid) begin
            wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            if (wr_ptr_q == LAST_IDX) begin
              state_q    <= ST_HDR0;
              tx_valid_q <= 1'b1;
              tx_data_q  <= FRAME_SYNC0;
`ifdef FRAME_CHECKSUM_EN
              csum_q     <= 8'h00;
`endif
            end
          end
        end
        ST_HDR0: begin
          if (xfer_d) begin
            state_q   <= ST_HDR1;
            tx_data_q <= FRAME_SYNC1;
          end
        end
        ST_HDR1: begin
          if (xfer_d) begin
            state_q   <= ST_LEN_HI;
            tx_data_q <= DEPTH_W[15:8];
          end
        end
        ST_LEN_HI: begin
          if (xfer_d) begin
            state_q   <= ST_LEN_LO;
            tx_data_q <= DEPTH_W[7:0];
          end
        end
        ST_LEN_LO: begin
          if (xfer_d) begin
            state_q   <= ST_DATA;
            tx_data_q <= rd_data_d;
          end
        end
        ST_DATA: begin
          // rd_ptr_q wraps to zero once the last sample is on tx_data.
          if (xfer_d) begin
            if (rd_ptr_q != {AW{1'b0}}) begin
              tx_data_q <= rd_data_d;
            end else begin
`ifdef FRAME_CHECKSUM_EN
              state_q   <= ST_CSUM;
              tx_data_q <= csum_q ^ tx_data_q;
`else
              state_q      <= ST_IDLE;
              tx_valid_q   <= 1'b0;
              tx_data_q    <= 8'h00;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
`endif
            end
          end
        end
`ifdef FRAME_CHECKSUM_EN
        ST_CSUM: begin
          if (xfer_d) begin
            state_q      <= ST_IDLE;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          tx_data_q  <= 8'h00;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_if.tx_data  = tx_data_q;
  assign tx_if.tx_valid = tx_valid_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;

endmodule
